// File: rtl/sd_read_arbiter_if.sv
// sd_read_arbiter_if: client request/ack lines plus the CMD17 read-engine handshake.
interface sd_read_arbiter_if;
   logic        init_done;
   logic        req0;
   logic        req1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [1:0]  gnt;
   logic        busy;
   logic        rd_re;
   logic [31:0] rd_addr;
   logic        rd_rend;
   logic        rd_rerr;
   modport slave (
      input  init_done, req0, req1, addr0, addr1, rd_rend, rd_rerr,
      output ack0, ack1, err0, err1, gnt, busy, rd_re, rd_addr
   );
   modport master (
      output init_done, req0, req1, addr0, addr1, rd_rend, rd_rerr,
      input  ack0, ack1, err0, err1, gnt, busy, rd_re, rd_addr
   );
endinterface

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin two-client sequencer for the SD single-block read engine,
// with bounded retry on engine error or watchdog timeout.
module sd_read_arbiter #(
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned TIMEOUT_W = 20,
   parameter int unsigned GAP_CYC   = 4
) (
   input logic              sdclk,
   input logic              reset,
   sd_read_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, DONE, FAIL, GAP} state_t;
   state_t                r_state;
   logic                  r_re, r_busy, r_ptr, r_fin;
   logic [31:0]           r_addr;
   logic [1:0]            r_gnt, r_ack, r_err;
   logic [7:0]            r_retry;
   logic [TIMEOUT_W-1:0]  r_wdog;
   logic [3:0]            r_gap;
   logic                  w_sel, w_last;
   logic [1:0]            w_live;
   logic [TIMEOUT_W-1:0]  w_wdog_nx;
   assign w_sel     = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
   assign w_last    = r_retry == 8'(MAX_RETRY);
   assign w_wdog_nx = r_wdog + TIMEOUT_W'(1);
   // a completion is only reported to an owner that is still requesting
   assign w_live    = r_gnt & {bus.req1, bus.req0};
   assign bus.rd_re   = r_re;
   assign bus.rd_addr = r_addr;
   assign bus.gnt     = r_gnt;
   assign bus.busy    = r_busy;
   assign bus.ack0    = r_ack[0];
   assign bus.ack1    = r_ack[1];
   assign bus.err0    = r_err[0];
   assign bus.err1    = r_err[1];
   always_ff @(posedge sdclk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_re    <= 1'b0;
         r_busy  <= 1'b0;
         r_ptr   <= 1'b0;
         r_fin   <= 1'b0;
         r_addr  <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_err   <= '0;
         r_retry <= '0;
         r_wdog  <= '0;
         r_gap   <= '0;
      end else begin
         r_ack <= '0;
         r_err <= '0;
         case (r_state)
            IDLE: if (bus.init_done && (bus.req0 || bus.req1)) begin
               r_addr  <= w_sel ? bus.addr1 : bus.addr0;
               r_gnt   <= w_sel ? 2'b10 : 2'b01;
               r_retry <= '0;
               r_wdog  <= '0;
               r_re    <= 1'b1;
               r_busy  <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: begin
               r_wdog <= w_wdog_nx;
               if (bus.rd_rend) begin
                  r_re    <= 1'b0;
                  r_ack   <= w_live;
                  r_state <= DONE;
               end else if (bus.rd_rerr || &w_wdog_nx) begin
                  r_re    <= 1'b0;
                  r_err   <= w_last ? w_live : 2'b00;
                  r_state <= FAIL;
               end
            end
            DONE: begin
               r_ptr   <= r_gnt[0];
               r_fin   <= 1'b1;
               r_gap   <= 4'(GAP_CYC - 1);
               r_state <= GAP;
            end
            FAIL: begin
               r_fin   <= w_last;
               r_ptr   <= w_last ? r_gnt[0] : r_ptr;
               r_retry <= w_last ? r_retry : r_retry + 8'd1;
               r_gap   <= 4'(GAP_CYC - 1);
               r_state <= GAP;
            end
            GAP: begin
               if (r_gap != 4'd0) r_gap <= r_gap - 4'd1;
               else if (r_fin) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_re    <= 1'b1;
                  r_wdog  <= '0;
                  r_state <= ISSUE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed checks of grant order, retry, exhaustion, timeout and reset abort.
module tb_sd_read_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   sd_read_arbiter_if b();
   sd_read_arbiter_if t();
   sd_read_arbiter dut (.sdclk(clk), .reset(reset), .bus(b));
   sd_read_arbiter #(.TIMEOUT_W(6)) dut_t (.sdclk(clk), .reset(reset), .bus(t));
   int nvec = 0, nfail = 0;
   int ack0_n, ack1_n, err0_n, err1_n, pulses, hi, lo, last_hi, last_lo, att, ecnt;
   int lat = 1000, fail_n = 0;
   bit both = 1'b0, pre_re = 1'b0;
   logic [1:0] pre_gnt = 2'b00;
   int gq[$];
   logic [31:0] aq[$];
   int t_err = 0, t_ack = 0, t_pulses = 0, t_hi = 0, t_last_hi = 0;
   bit t_pre = 1'b0;
   // engine model and monitor for the main instance
   always @(negedge clk) begin
      if (b.ack0) ack0_n++;
      if (b.ack1) ack1_n++;
      if (b.err0) err0_n++;
      if (b.err1) err1_n++;
      if (b.rd_re) begin
         if (!pre_re) begin
            pulses++; att++; last_lo = lo; hi = 0; ecnt = 0;
            aq.push_back(b.rd_addr);
         end
         hi++; ecnt++;
         if (ecnt == lat) begin
            if (both) begin b.rd_rend = 1'b1; b.rd_rerr = 1'b1; end
            else if (att <= fail_n) b.rd_rerr = 1'b1;
            else b.rd_rend = 1'b1;
         end
      end else begin
         if (pre_re) begin last_hi = hi; lo = 0; end
         lo++;
         b.rd_rend = 1'b0;
         b.rd_rerr = 1'b0;
      end
      if (b.gnt != 2'b00 && pre_gnt == 2'b00) gq.push_back(int'(b.gnt[1]));
      pre_re  = b.rd_re;
      pre_gnt = b.gnt;
   end
   // silent engine behind the short-watchdog instance
   always @(negedge clk) begin
      if (t.err0) t_err++;
      if (t.ack0) t_ack++;
      if (t.rd_re) begin
         if (!t_pre) t_pulses++;
         t_hi++;
      end else begin
         if (t_pre) t_last_hi = t_hi;
         t_hi = 0;
      end
      t_pre = t.rd_re;
   end
   task automatic step(input int n = 1);
      repeat (n) begin @(negedge clk); #1; end
   endtask
   task automatic clr();
      ack0_n = 0; ack1_n = 0; err0_n = 0; err1_n = 0;
      pulses = 0; att = 0; gq.delete(); aq.delete();
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 100 && b.busy; i++) step();
      chk("idle_reached", 32'(b.busy), 0);
   endtask
   initial begin
      int n;
      b.init_done = 0; b.req0 = 0; b.req1 = 0; b.addr0 = 0; b.addr1 = 0;
      b.rd_rend = 0; b.rd_rerr = 0;
      t.init_done = 0; t.req0 = 0; t.req1 = 0; t.addr0 = 0; t.addr1 = 0;
      t.rd_rend = 0; t.rd_rerr = 0;
      clr();
      reset = 1'b1;
      step(3);
      chk("rst_re", 32'(b.rd_re), 0);
      chk("rst_addr", b.rd_addr, 0);
      chk("rst_gnt", 32'(b.gnt), 0);
      chk("rst_busy", 32'(b.busy), 0);
      chk("rst_ackerr", 32'({b.ack0, b.ack1, b.err0, b.err1}), 0);
      reset = 1'b0;
      step();
      // requests are ignored until the card is initialised
      b.addr0 = 32'h0000_0800; b.req0 = 1;
      step(20);
      chk("noinit_pulses", pulses, 0);
      chk("noinit_gnt", 32'(b.gnt), 0);
      // single read
      clr(); lat = 600; b.init_done = 1;
      for (int i = 0; i < 800 && ack0_n == 0; i++) step();
      chk("single_ack0", ack0_n, 1);
      chk("single_hi", last_hi, 600);
      chk("single_addr", b.rd_addr, 32'h0000_0800);
      chk("single_gnt", 32'(b.gnt), 1);
      b.req0 = 0;
      n = 0;
      while (b.gnt != 2'b00 && n < 20) begin step(); n++; end
      chk("single_gnt_release", n, 5);
      chk("single_one_ack", ack0_n, 1);
      // contention from a fresh reset
      reset = 1'b1; step(); reset = 1'b0;
      clr(); lat = 10;
      b.addr0 = 32'h0000_1000; b.addr1 = 32'h0000_2000;
      b.req0 = 1; b.req1 = 1;
      for (int i = 0; i < 300 && ack0_n + ack1_n < 4; i++) step();
      b.req0 = 0; b.req1 = 0;
      chk("cont_ack0", ack0_n, 2);
      chk("cont_ack1", ack1_n, 2);
      chk("cont_order", gq.size() == 4 ? 32'((gq[0] << 3) | (gq[1] << 2) | (gq[2] << 1) | gq[3]) : 32'hF, 32'h5);
      chk("cont_addr1", aq.size() > 1 ? aq[1] : 32'hX, 32'h0000_2000);
      chk("cont_addr2", aq.size() > 2 ? aq[2] : 32'hX, 32'h0000_1000);
      chk("cont_low", last_lo, 6);
      wait_idle();
      // two engine errors then success
      clr(); lat = 5; fail_n = 2; b.addr0 = 32'h0001_2345; b.req0 = 1;
      for (int i = 0; i < 200 && ack0_n + err0_n == 0; i++) step();
      b.req0 = 0;
      chk("retry_ack0", ack0_n, 1);
      chk("retry_err0", err0_n, 0);
      chk("retry_pulses", pulses, 3);
      chk("retry_addr_first", aq.size() > 0 ? aq[0] : 32'hX, 32'h0001_2345);
      chk("retry_addr_last", aq.size() > 2 ? aq[2] : 32'hX, 32'h0001_2345);
      chk("retry_low", last_lo, 5);
      wait_idle();
      // every attempt fails
      clr(); fail_n = 99; b.addr1 = 32'h00AB_CDEF; b.req1 = 1;
      for (int i = 0; i < 300 && ack1_n + err1_n == 0; i++) step();
      b.req1 = 0;
      chk("exh_err1", err1_n, 1);
      chk("exh_ack1", ack1_n, 0);
      chk("exh_pulses", pulses, 4);
      wait_idle();
      clr(); fail_n = 0; b.req0 = 1; b.req1 = 1;
      for (int i = 0; i < 100 && ack0_n + ack1_n == 0; i++) step();
      b.req0 = 0; b.req1 = 0;
      chk("exh_next_owner", gq.size() > 0 ? 32'(gq[0]) : 32'hF, 0);
      chk("exh_next_ack0", ack0_n, 1);
      wait_idle();
      // end and error flags together
      clr(); both = 1; lat = 7; b.req0 = 1;
      for (int i = 0; i < 100 && ack0_n + err0_n == 0; i++) step();
      b.req0 = 0; both = 0;
      chk("both_ack0", ack0_n, 1);
      chk("both_err0", err0_n, 0);
      chk("both_pulses", pulses, 1);
      wait_idle();
      // requester withdraws mid-read
      clr(); lat = 30; b.req0 = 1;
      step(10);
      b.req0 = 0;
      wait_idle();
      chk("drop_ack0", ack0_n, 0);
      chk("drop_err0", err0_n, 0);
      chk("drop_pulses", pulses, 1);
      // reset during ISSUE
      clr(); lat = 50; b.req0 = 1;
      step(10);
      chk("abort_pre_re", 32'(b.rd_re), 1);
      #2 reset = 1'b1;
      #1;
      chk("abort_re", 32'(b.rd_re), 0);
      chk("abort_gnt", 32'(b.gnt), 0);
      chk("abort_busy", 32'(b.busy), 0);
      b.req0 = 0;
      step(2);
      reset = 1'b0;
      step(100);
      chk("abort_no_ack", ack0_n, 0);
      chk("abort_pulses", pulses, 1);
      // watchdog expiry on a silent engine
      t.init_done = 1; t.addr0 = 32'h0000_0042; t.req0 = 1;
      for (int i = 0; i < 1000 && t_err + t_ack == 0; i++) step();
      t.req0 = 0;
      chk("tmo_err0", t_err, 1);
      chk("tmo_ack0", t_ack, 0);
      chk("tmo_pulses", t_pulses, 4);
      chk("tmo_hi", t_last_hi, 63);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
